// File: rtl/exec_pkg.sv
// exec_pkg: shared execute-stage definitions.
// Contents:
//   - string-instruction kind and repeat-prefix enums
//   - rep_string_seq FSM state enum
//   - alu1 opcode codes
//   - operand-size codes
//   - EFLAGS bit indices
//   - normalisation helpers that fold the reserved encodings
package exec_pkg;

    typedef enum logic [1:0] {
        StrMovs = 2'b00,
        StrCmps = 2'b01,
        StrStos = 2'b10,
        StrRsvd = 2'b11
    } str_kind_e;

    typedef enum logic [1:0] {
        RepNone = 2'b00,
        RepE    = 2'b01,
        RepNe   = 2'b10,
        RepRsvd = 2'b11
    } rep_mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRdSrc,
        StRdDst,
        StWrDst,
        StUpdSrc,
        StUpdDst,
        StDone
    } seq_state_e;

    // alu1 opcodes
    localparam logic [3:0] AluOpPass    = 4'b0000;
    localparam logic [3:0] AluOpOr      = 4'b0001;
    localparam logic [3:0] AluOpAnd     = 4'b0010;
    localparam logic [3:0] AluOpXor     = 4'b0011;
    localparam logic [3:0] AluOpSal     = 4'b0100;
    localparam logic [3:0] AluOpSar     = 4'b0101;
    localparam logic [3:0] AluOpShr     = 4'b0110;
    localparam logic [3:0] AluOpAdd     = 4'b1000;
    localparam logic [3:0] AluOpSub     = 4'b1001;
    localparam logic [3:0] AluOpPtrStep = 4'b1010;

    // Operand sizes
    localparam logic [1:0] OpSizeByte  = 2'b00;
    localparam logic [1:0] OpSizeWord  = 2'b01;
    localparam logic [1:0] OpSizeDword = 2'b10;

    // EFLAGS bit positions inside cmps_flags
    localparam int unsigned FlagCf = 0;
    localparam int unsigned FlagPf = 1;
    localparam int unsigned FlagAf = 2;
    localparam int unsigned FlagZf = 3;
    localparam int unsigned FlagSf = 4;
    localparam int unsigned FlagOf = 5;

    // The reserved kind behaves as STOS.
    function automatic str_kind_e norm_kind(logic [1:0] k);
        return (k == 2'b11) ? StrStos : str_kind_e'(k);
    endfunction

    // The reserved prefix behaves as no prefix.
    function automatic rep_mode_e norm_rep(logic [1:0] r);
        return (r == 2'b11) ? RepNone : rep_mode_e'(r);
    endfunction

endpackage

// File: rtl/rep_string_seq_if.sv
// rep_string_seq_if: memory read/write request handshake between the string
// sequencer and the memory stage.
// Signals:
//   mem_rd_req  read request, held until acknowledged
//   mem_rd_sel  read address source: 0 = ESI, 1 = EDI
//   mem_wr_req  write request to [EDI], held until acknowledged
//   mem_rd_ack  read data valid on mem_out this cycle
//   mem_wr_ack  write accepted this cycle
// Modports:
//   master  the sequencer side
//   slave   the memory side
interface rep_string_seq_if;

    logic mem_rd_req;
    logic mem_rd_sel;
    logic mem_wr_req;
    logic mem_rd_ack;
    logic mem_wr_ack;

    modport master (
        output mem_rd_req,
        output mem_rd_sel,
        output mem_wr_req,
        input  mem_rd_ack,
        input  mem_wr_ack
    );

    modport slave (
        input  mem_rd_req,
        input  mem_rd_sel,
        input  mem_wr_req,
        output mem_rd_ack,
        output mem_wr_ack
    );

endinterface

// File: rtl/rep_term_chk.sv
// rep_term_chk: combinational termination logic for REP-prefixed string
// instructions.
// Inputs:
//   rep_mode  latched (normalised) repeat prefix
//   str_kind  latched (normalised) instruction kind
//   ecx_q     current internal count
//   zf_q      ZF captured from the last CMPS compare
// Outputs:
//   rep_active       a repeat prefix is in effect
//   stop_at_check    count exhausted before the next iteration
//   stop_after_iter  retire once the current iteration has finished
module rep_term_chk
    import exec_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  rep_mode_e         rep_mode,
    input  str_kind_e         str_kind,
    input  logic [DW-1:0]     ecx_q,
    input  logic              zf_q,
    output logic              rep_active,
    output logic              stop_at_check,
    output logic              stop_after_iter
);

    logic is_cmps;

    always_comb begin
        is_cmps       = (str_kind == StrCmps);
        rep_active    = (rep_mode == RepE) || (rep_mode == RepNe);
        stop_at_check = rep_active && (ecx_q == '0);
        // REPE/REPNE only look at ZF for CMPS; MOVS/STOS repeat on count alone.
        stop_after_iter = !rep_active
                        || (is_cmps && (rep_mode == RepE) && !zf_q)
                        || (is_cmps && (rep_mode == RepNe) && zf_q);
    end

endmodule

// File: rtl/rep_string_seq.sv
// rep_string_seq: execute-stage sequencer for MOVS/CMPS/STOS, with optional
// REP/REPE/REPNE prefixes.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            launch pulse from decode; ignored while busy
//   str_kind         00 MOVS, 01 CMPS, 10 STOS, 11 treated as STOS
//   rep_mode         00 none, 01 REP/REPE, 10 REPNE, 11 treated as none
//   ecx_in           ECX value sampled at start
//   stall            freezes the FSM and counters and suppresses strobes
//   mem              memory request handshake (master side)
//   cmps_zf          ZF from alu1 cmps_flags, valid with the EDI read ack
//   busy             high from the cycle after start through done
//   latch_mem        load mem_out_latched (ESI operand read ack)
//   ld_cmps_flags    commit cmps_flags (EDI operand read ack)
//   alu1_op          alu1 opcode (pointer step during UPD states)
//   alu1_op_size     alu1 operand size, always dword
//   alu_sr1_sel      alu1 sr1 source: 0 ESI, 1 EDI
//   ld_esi, ld_edi   write alu_res1 back to ESI / EDI
//   ld_ecx, ecx_out  write the decremented count back to ECX
//   done             one-cycle retire pulse
module rep_string_seq
    import exec_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter logic [3:0]  OP_PTR_STEP = AluOpPtrStep,
    parameter logic [1:0]  OP_SIZE_DW  = OpSizeDword
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              str_kind,
    input  logic [1:0]              rep_mode,
    input  logic [DW-1:0]           ecx_in,
    input  logic                    stall,
    rep_string_seq_if.master        mem,
    input  logic                    cmps_zf,
    output logic                    busy,
    output logic                    latch_mem,
    output logic                    ld_cmps_flags,
    output logic [3:0]              alu1_op,
    output logic [1:0]              alu1_op_size,
    output logic                    alu_sr1_sel,
    output logic                    ld_esi,
    output logic                    ld_edi,
    output logic                    ld_ecx,
    output logic [DW-1:0]           ecx_out,
    output logic                    done
);

    seq_state_e    state_q, state_d;
    str_kind_e     kind_q, kind_d;
    rep_mode_e     rep_q, rep_d;
    logic [DW-1:0] ecx_q, ecx_d;
    logic          zf_q, zf_d;

    // Registered outputs, decoded from the next state so they line up with state_q.
    logic          busy_q;
    logic          rd_req_q;
    logic          rd_sel_q;
    logic          wr_req_q;
    logic [3:0]    alu1_op_q;
    logic          alu_sr1_sel_q;
    logic          ld_esi_q;
    logic          ld_edi_q;
    logic          ld_ecx_q;
    logic [DW-1:0] ecx_out_q;
    logic          done_q;

    logic          rep_active;
    logic          stop_at_check;
    logic          stop_after_iter;

    rep_term_chk #(
        .DW (DW)
    ) u_term_chk (
        .rep_mode        (rep_q),
        .str_kind        (kind_q),
        .ecx_q           (ecx_q),
        .zf_q            (zf_q),
        .rep_active      (rep_active),
        .stop_at_check   (stop_at_check),
        .stop_after_iter (stop_after_iter)
    );

    // Next-state logic; a stall holds everything, so acks seen during a stall are dropped.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        rep_d   = rep_q;
        ecx_d   = ecx_q;
        zf_d    = zf_q;
        if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        kind_d  = norm_kind(str_kind);
                        rep_d   = norm_rep(rep_mode);
                        ecx_d   = ecx_in;
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (stop_at_check) begin
                        state_d = StDone;
                    end else if (kind_q == StrStos) begin
                        state_d = StWrDst;
                    end else begin
                        state_d = StRdSrc;
                    end
                end
                StRdSrc: begin
                    if (mem.mem_rd_ack) begin
                        state_d = (kind_q == StrCmps) ? StRdDst : StWrDst;
                    end
                end
                StRdDst: begin
                    if (mem.mem_rd_ack) begin
                        zf_d    = cmps_zf;
                        state_d = StUpdSrc;
                    end
                end
                StWrDst: begin
                    if (mem.mem_wr_ack) begin
                        state_d = (kind_q == StrStos) ? StUpdDst : StUpdSrc;
                    end
                end
                StUpdSrc: begin
                    state_d = StUpdDst;
                end
                StUpdDst: begin
                    if (rep_active) begin
                        ecx_d = ecx_q - DW'(1);
                    end
                    state_d = stop_after_iter ? StDone : StCheck;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            kind_q        <= StrMovs;
            rep_q         <= RepNone;
            ecx_q         <= '0;
            zf_q          <= 1'b0;
            busy_q        <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            alu1_op_q     <= AluOpPass;
            alu_sr1_sel_q <= 1'b0;
            ld_esi_q      <= 1'b0;
            ld_edi_q      <= 1'b0;
            ld_ecx_q      <= 1'b0;
            ecx_out_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            rep_q         <= rep_d;
            ecx_q         <= ecx_d;
            zf_q          <= zf_d;
            busy_q        <= (state_d != StIdle);
            rd_req_q      <= (state_d == StRdSrc) || (state_d == StRdDst);
            rd_sel_q      <= (state_d == StRdDst);
            wr_req_q      <= (state_d == StWrDst);
            alu1_op_q     <= ((state_d == StUpdSrc) || (state_d == StUpdDst)) ?
                             OP_PTR_STEP : AluOpPass;
            alu_sr1_sel_q <= (state_d == StUpdDst);
            ld_esi_q      <= (state_d == StUpdSrc);
            ld_edi_q      <= (state_d == StUpdDst);
            // Entering UPD_DST only from WR_DST/UPD_SRC, where ecx_d == ecx_q.
            ld_ecx_q      <= (state_d == StUpdDst) && rep_active;
            ecx_out_q     <= ((state_d == StUpdDst) && rep_active) ? (ecx_d - DW'(1)) : '0;
            done_q        <= (state_d == StDone);
        end
    end

    assign mem.mem_rd_req = rd_req_q;
    assign mem.mem_rd_sel = rd_sel_q;
    assign mem.mem_wr_req = wr_req_q;

    assign busy          = busy_q;
    assign alu1_op       = alu1_op_q;
    assign alu1_op_size  = OP_SIZE_DW;
    assign alu_sr1_sel   = alu_sr1_sel_q;
    assign ecx_out       = ecx_out_q;

    // Write-back strobes and done are suppressed for the duration of a stall.
    assign ld_esi        = ld_esi_q & ~stall;
    assign ld_edi        = ld_edi_q & ~stall;
    assign ld_ecx        = ld_ecx_q & ~stall;
    assign done          = done_q & ~stall;
    assign latch_mem     = (state_q == StRdSrc) & mem.mem_rd_ack & ~stall;
    assign ld_cmps_flags = (state_q == StRdDst) & mem.mem_rd_ack & ~stall;

endmodule
